// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
// Bundles every signal that alu_arbiter exchanges with the outside world.
// The two request channels, the tagged response channel and the ALU side
// are all carried here. clk and rst stay plain module ports.
//   req0_*/req1_* : valid/ready request channels (opcode, operands A/B)
//   rsp_*         : valid/ready response channel (id, result, flags, error)
//   alu_*         : operand/opcode drive to the ALU, result/flags back
// Modports:
//   slave  - the arbiter's view
//   master - the view of the surrounding system (requesters, consumer, ALU)
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_opcode;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_opcode;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_negative;
    logic             rsp_zero;
    logic             rsp_error;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_opcode;
    logic [WIDTH-1:0] alu_result;
    logic             alu_negative;
    logic             alu_zero;

    modport slave (
        input  req0_valid, req0_opcode, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_opcode, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_negative, rsp_zero, rsp_error,
        input  rsp_ready,
        output alu_a, alu_b, alu_opcode,
        input  alu_result, alu_negative, alu_zero
    );

    modport master (
        output req0_valid, req0_opcode, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_opcode, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_negative, rsp_zero, rsp_error,
        output rsp_ready,
        input  alu_a, alu_b, alu_opcode,
        output alu_result, alu_negative, alu_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU between two requesters. The requesters are
// served round-robin, one operation at a time. The winner's operands and
// opcode are registered onto the ALU inputs. The ALU gets one cycle to
// settle, then its result and flags are captured. They are returned on a
// tagged valid/ready response channel.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - alu_arbiter_if.slave (request, response and ALU signals)
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    localparam logic [3:0] OP_PASS_A = 4'b0100;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q;
    logic             last_grant_q;
    logic             err_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [3:0]       alu_opcode_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_negative_q;
    logic             rsp_zero_q;
    logic             rsp_error_q;

    // Grant and operand selection (combinational, only meaningful in IDLE)
    logic             grant_d;      // 1 selects requester 1
    logic             accept_d;
    logic [3:0]       sel_opcode_d;
    logic [WIDTH-1:0] sel_a_d;
    logic [WIDTH-1:0] sel_b_d;
    logic             sel_illegal_d;

    always_comb begin
        // On a tie the requester that did not win last time gets the grant
        if (bus.req0_valid && bus.req1_valid) begin
            grant_d = ~last_grant_q;
        end else begin
            grant_d = bus.req1_valid;
        end
        accept_d      = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
        sel_opcode_d  = grant_d ? bus.req1_opcode : bus.req0_opcode;
        sel_a_d       = grant_d ? bus.req1_a      : bus.req0_a;
        sel_b_d       = grant_d ? bus.req1_b      : bus.req0_b;
        // Only opcodes 0..4 exist on the ALU
        sel_illegal_d = (sel_opcode_d > OP_PASS_A);
    end

    assign bus.req0_ready = accept_d && !grant_d;
    assign bus.req1_ready = accept_d &&  grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            err_q          <= 1'b0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_opcode_q   <= OP_PASS_A;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_result_q   <= '0;
            rsp_negative_q <= 1'b0;
            rsp_zero_q     <= 1'b0;
            rsp_error_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        alu_a_q      <= sel_a_d;
                        alu_b_q      <= sel_b_d;
                        // Illegal opcodes never reach the ALU; it just sees pass-A
                        alu_opcode_q <= sel_illegal_d ? OP_PASS_A : sel_opcode_d;
                        err_q        <= sel_illegal_d;
                        rsp_id_q     <= grant_d;
                        last_grant_q <= grant_d;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU inputs have been stable for a full cycle: capture
                    rsp_valid_q <= 1'b1;
                    rsp_error_q <= err_q;
                    if (err_q) begin
                        rsp_result_q   <= '0;
                        rsp_negative_q <= 1'b0;
                        rsp_zero_q     <= 1'b0;
                    end else begin
                        rsp_result_q   <= bus.alu_result;
                        rsp_negative_q <= bus.alu_negative;
                        rsp_zero_q     <= bus.alu_zero;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    // Response registers hold until the consumer takes them
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.alu_a        = alu_a_q;
    assign bus.alu_b        = alu_b_q;
    assign bus.alu_opcode   = alu_opcode_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_negative = rsp_negative_q;
    assign bus.rsp_zero     = rsp_zero_q;
    assign bus.rsp_error    = rsp_error_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Self-checking bench for alu_arbiter. It contains a behavioural ALU,
// a table of single-request vectors and hand-written sequences for
// arbitration, backpressure and reset during an operation. Expected
// responses are queued when requests are issued. They are compared when
// the response handshake completes.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(32)) bus ();

    alu_arbiter #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural ALU model connected to the ALU side of the arbiter
    logic [31:0] alu_r;
    always_comb begin
        case (bus.alu_opcode)
            4'b0000: alu_r = bus.alu_a + bus.alu_b;
            4'b0001: alu_r = bus.alu_a + 32'd1;
            4'b0010: alu_r = 32'd0 - bus.alu_a;
            4'b0011: alu_r = bus.alu_a - bus.alu_b;
            default: alu_r = bus.alu_a;
        endcase
        bus.alu_result   = alu_r;
        bus.alu_negative = alu_r[31];
        bus.alu_zero     = (alu_r == 32'd0);
    end

    typedef struct {
        bit          id;
        logic [31:0] res;
        bit          neg;
        bit          zero;
        bit          err;
    } exp_t;

    typedef struct {
        bit          id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  exp_op;
        logic [31:0] e_res;
        bit          e_neg;
        bit          e_zero;
        bit          e_err;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic exp_t mk(bit id, logic [31:0] res, bit neg, bit zero, bit err);
        exp_t e;
        e.id = id; e.res = res; e.neg = neg; e.zero = zero; e.err = err;
        return e;
    endfunction

    // Response monitor: one line per completed response
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got response id=%0d result=0x%08h, expected none",
                         bus.rsp_id, bus.rsp_result);
            end else begin
                mon_e = sb.pop_front();
                $display("rsp id=%0d result=0x%08h neg=%0d zero=%0d err=%0d",
                         bus.rsp_id, bus.rsp_result, bus.rsp_negative, bus.rsp_zero, bus.rsp_error);
                check("rsp_id",       {31'd0, bus.rsp_id},       {31'd0, mon_e.id});
                check("rsp_result",   bus.rsp_result,            mon_e.res);
                check("rsp_negative", {31'd0, bus.rsp_negative}, {31'd0, mon_e.neg});
                check("rsp_zero",     {31'd0, bus.rsp_zero},     {31'd0, mon_e.zero});
                check("rsp_error",    {31'd0, bus.rsp_error},    {31'd0, mon_e.err});
            end
        end
    end

    task automatic drive_req(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id == 1'b0) begin
            bus.req0_valid = 1'b1; bus.req0_opcode = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_opcode = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic drop(input bit id);
        if (id == 1'b0) bus.req0_valid = 1'b0;
        else            bus.req1_valid = 1'b0;
    endtask

    function automatic bit taken(input bit id);
        return id ? (bus.req1_valid && bus.req1_ready) : (bus.req0_valid && bus.req0_ready);
    endfunction

    // Issue a request and hold it until accepted.
    // Returns 1 time unit after the accepting edge, i.e. inside the EXEC cycle.
    task automatic send(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int cnt;
        cnt = 0;
        drive_req(id, op, a, b);
        @(negedge clk);
        while (!taken(id) && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        if (!taken(id)) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: requester %0d got ready=0, expected 1", id);
        end
        @(posedge clk);
        #1;
        drop(id);
    endtask

    task automatic wait_drain();
        int cnt;
        cnt = 0;
        while (sb.size() != 0 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending responses, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    localparam int NV = 9;
    vec_t vec[NV];

    initial begin
        int g[$];
        int cnt;
        int n0;
        bit a0;
        bit a1;

        vec[0] = '{1'b0, 4'b0000, 32'd5,          32'd7, 4'b0000, 32'd12,         1'b0, 1'b0, 1'b0};
        vec[1] = '{1'b1, 4'b1010, 32'd9,          32'd0, 4'b0100, 32'd0,          1'b0, 1'b0, 1'b1};
        vec[2] = '{1'b0, 4'b0001, 32'hFFFF_FFFF,  32'd0, 4'b0001, 32'd0,          1'b0, 1'b1, 1'b0};
        vec[3] = '{1'b1, 4'b0011, 32'd3,          32'd5, 4'b0011, 32'hFFFF_FFFE,  1'b1, 1'b0, 1'b0};
        vec[4] = '{1'b0, 4'b0100, 32'h8000_0000,  32'd1, 4'b0100, 32'h8000_0000,  1'b1, 1'b0, 1'b0};
        vec[5] = '{1'b1, 4'b0101, 32'd4,          32'd4, 4'b0100, 32'd0,          1'b0, 1'b0, 1'b1};
        vec[6] = '{1'b0, 4'b1111, 32'hFFFF_FFFF,  32'd2, 4'b0100, 32'd0,          1'b0, 1'b0, 1'b1};
        vec[7] = '{1'b0, 4'b0000, 32'hFFFF_FFFF,  32'd1, 4'b0000, 32'd0,          1'b0, 1'b1, 1'b0};
        vec[8] = '{1'b1, 4'b0010, 32'd0,          32'd0, 4'b0010, 32'd0,          1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        bus.rsp_ready   = 1'b1;
        bus.req0_valid  = 1'b0; bus.req0_opcode = 4'd0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
        bus.req1_valid  = 1'b0; bus.req1_opcode = 4'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid",  {31'd0, bus.rsp_valid},  32'd0);
        check("reset_alu_opcode", {28'd0, bus.alu_opcode}, 32'd4);
        check("reset_alu_a",      bus.alu_a,               32'd0);
        check("reset_alu_b",      bus.alu_b,               32'd0);
        check("reset_rsp_result", bus.rsp_result,          32'd0);
        check("reset_rsp_error",  {31'd0, bus.rsp_error},  32'd0);
        check("reset_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Both held valid: first tie after reset goes to req0, then strict alternation.
        // req1's operands start as junk and are corrected while it waits.
        sb.push_back(mk(1'b0, 32'd0,         1'b0, 1'b1, 1'b0));
        sb.push_back(mk(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(1'b0, 32'h55,        1'b0, 1'b0, 1'b0));
        drive_req(1'b0, 4'b0011, 32'd3, 32'd3);
        drive_req(1'b1, 4'b0010, 32'hDEAD_0000, 32'd0);
        cnt = 0;
        n0  = 0;
        while (g.size() < 3 && cnt < 60) begin
            @(negedge clk);
            a0 = taken(1'b0);
            a1 = taken(1'b1);
            if (a0) g.push_back(0);
            if (a1) g.push_back(1);
            @(posedge clk);
            #1;
            if (a0) begin
                if (n0 == 0) begin
                    drive_req(1'b0, 4'b0100, 32'h55, 32'd0);
                    bus.req1_a = 32'd1;
                end else begin
                    drop(1'b0);
                end
                n0++;
            end
            if (a1) drop(1'b1);
            cnt++;
        end
        drop(1'b0);
        drop(1'b1);
        check("rr_grant_count", g.size(), 32'd3);
        if (g.size() == 3) begin
            check("rr_grant0", g[0], 32'd0);
            check("rr_grant1", g[1], 32'd1);
            check("rr_grant2", g[2], 32'd0);
        end
        wait_drain();

        // Single-request vectors
        for (int i = 0; i < NV; i++) begin
            sb.push_back(mk(vec[i].id, vec[i].e_res, vec[i].e_neg, vec[i].e_zero, vec[i].e_err));
            send(vec[i].id, vec[i].op, vec[i].a, vec[i].b);
            @(negedge clk);
            check("exec_alu_opcode", {28'd0, bus.alu_opcode}, {28'd0, vec[i].exp_op});
            check("exec_alu_a",      bus.alu_a,               vec[i].a);
            check("exec_rsp_valid",  {31'd0, bus.rsp_valid},  32'd0);
            @(negedge clk);
            check("lat_rsp_valid",   {31'd0, bus.rsp_valid},  32'd1);
            wait_drain();
        end

        // Backpressure: response held, no grants until the handshake
        bus.rsp_ready = 1'b0;
        sb.push_back(mk(1'b0, 32'd3, 1'b0, 1'b0, 1'b0));
        send(1'b0, 4'b0000, 32'd1, 32'd2);
        cnt = 0;
        @(negedge clk);
        while (!bus.rsp_valid && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("bp_rsp_valid_seen", {31'd0, bus.rsp_valid}, 32'd1);
        @(posedge clk);
        #1;
        sb.push_back(mk(1'b1, 32'd7, 1'b0, 1'b0, 1'b0));
        drive_req(1'b1, 4'b0100, 32'd7, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp_valid",  {31'd0, bus.rsp_valid},  32'd1);
            check("bp_rsp_result", bus.rsp_result,          32'd3);
            check("bp_rsp_id",     {31'd0, bus.rsp_id},     32'd0);
            check("bp_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
            check("bp_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
        @(negedge clk);
        check("bp_after_rsp_valid",  {31'd0, bus.rsp_valid},  32'd0);
        check("bp_after_req1_ready", {31'd0, bus.req1_ready}, 32'd1);
        @(posedge clk);
        #1;
        drop(1'b1);
        wait_drain();

        // Reset during EXEC: the increment is dropped without a response
        send(1'b0, 4'b0001, 32'hFFFF_FFFF, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_alu_a",      bus.alu_a,               32'd0);
        check("rst_mid_alu_opcode", {28'd0, bus.alu_opcode}, 32'd4);
        check("rst_mid_rsp_id",     {31'd0, bus.rsp_id},     32'd0);
        check("rst_mid_rsp_result", bus.rsp_result,          32'd0);
        for (int k = 0; k < 5; k++) begin
            check("rst_mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        sb.push_back(mk(1'b1, 32'h42, 1'b0, 1'b0, 1'b0));
        send(1'b1, 4'b0000, 32'h40, 32'd2);
        wait_drain();

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
